// File: rtl/sdr_pkg.sv
// Shared tag encodings and FSM state type for the sum/diff recovery block.
package sdr_pkg;

    localparam logic [1:0] OP_A    = 2'b00;
    localparam logic [1:0] OP_B    = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_DIFF = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/sdr_solve.sv
// Combinational solver: two tagged beats (distinct tags, any order) -> operand pair a, b.
// With SDR_CHECK_EN defined, err flags out-of-range results, bad direct-beat sign bits
// and odd sum+diff; otherwise err is constant 0.
module sdr_solve
    import sdr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]  sel0_i,
    input  logic [DW:0] c0_i,
    input  logic [1:0]  sel1_i,
    input  logic [DW:0] c1_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic          err_o
);

    localparam int XW = DW + 2;

    logic [1:0]  sel [2];
    logic [DW:0] c   [2];
    logic        has_a, has_b, has_s, has_d;
    logic [DW:0] raw_a, raw_b;
    logic signed [XW-1:0] va, vb, vs, vd, sd_sum, ra, rb;

    assign sel[0] = sel0_i;
    assign sel[1] = sel1_i;
    assign c[0]   = c0_i;
    assign c[1]   = c1_i;

    // Sort the two beats by tag and solve for a and b at DW+2 bits.
    always_comb begin
        has_a = 1'b0;
        has_b = 1'b0;
        has_s = 1'b0;
        has_d = 1'b0;
        raw_a = '0;
        raw_b = '0;
        vs    = '0;
        vd    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            case (sel[i])
                OP_A:    begin has_a = 1'b1; raw_a = c[i]; end
                OP_B:    begin has_b = 1'b1; raw_b = c[i]; end
                OP_SUM:  begin has_s = 1'b1; vs = XW'($signed(c[i])); end
                default: begin has_d = 1'b1; vd = XW'($signed(c[i])); end
            endcase
        end
        // Direct beats only carry DW significant bits.
        va     = XW'($signed(raw_a[DW-1:0]));
        vb     = XW'($signed(raw_b[DW-1:0]));
        sd_sum = vs + vd;
        ra     = '0;
        rb     = '0;
        if (has_a && has_b) begin
            ra = va;
            rb = vb;
        end else if (has_a && has_s) begin
            ra = va;
            rb = vs - va;
        end else if (has_a && has_d) begin
            ra = va;
            rb = va - vd;
        end else if (has_b && has_s) begin
            ra = vs - vb;
            rb = vb;
        end else if (has_b && has_d) begin
            ra = vd + vb;
            rb = vb;
        end else if (has_s && has_d) begin
            ra = sd_sum >>> 1;
            rb = (vs - vd) >>> 1;
        end
    end

    assign a_o = ra[DW-1:0];
    assign b_o = rb[DW-1:0];

`ifdef SDR_CHECK_EN
    logic range_bad, direct_bad, odd_bad;

    // Result fits DW signed bits only if the top three bits agree.
    assign range_bad  = ((ra[XW-1:DW-1] != '0) && (ra[XW-1:DW-1] != '1)) ||
                        ((rb[XW-1:DW-1] != '0) && (rb[XW-1:DW-1] != '1));
    assign direct_bad = (has_a && (raw_a[DW] != raw_a[DW-1])) ||
                        (has_b && (raw_b[DW] != raw_b[DW-1]));
    assign odd_bad    = has_s && has_d && sd_sum[0];
    assign err_o      = range_bad || direct_bad || odd_bad;
`else
    logic unused_bits;

    assign unused_bits = ^{ra[XW-1:DW], rb[XW-1:DW], raw_a[DW], raw_b[DW], sd_sum[0]};
    assign err_o       = 1'b0;
`endif

endmodule

// File: rtl/sum_diff_recover.sv
// Recovers the signed operand pair (a, b) from two tagged ALU results.
// Holds the first beat, pairs it with the next beat of a different tag, and
// registers the solved pair behind a valid/ready output slot.
// Optional consistency checking is enabled by defining SDR_CHECK_EN.
module sum_diff_recover
    import sdr_pkg::*;
#(
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sel,
    input  logic [DW:0]   in_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          out_err,
    output logic          drop_pulse
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e        state_q, state_d;
    logic [1:0]    hsel_q, hsel_d;
    logic [DW:0]   hc_q, hc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] oa_q, oa_d, ob_q, ob_d;
    logic          oe_q, oe_d;
    logic          drop_q, drop_d;
    logic          accept, expire, load;
    logic [DW-1:0] sa, sb;
    logic          se;

    assign in_ready = rst_n && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign expire   = (TIMEOUT_CYC > 0) && (state_q == HOLD) && !accept &&
                      (cnt_q == CW'(TIMEOUT_CYC - 1));

    sdr_solve #(.DW(DW)) u_solve (
        .sel0_i (hsel_q),
        .c0_i   (hc_q),
        .sel1_i (in_sel),
        .c1_i   (in_c),
        .a_o    (sa),
        .b_o    (sb),
        .err_o  (se)
    );

    // State, held beat, timeout counter and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hsel_q  <= '0;
            hc_q    <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            oa_q    <= '0;
            ob_q    <= '0;
            oe_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hsel_q  <= hsel_d;
            hc_q    <= hc_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            oe_q    <= oe_d;
            drop_q  <= drop_d;
        end
    end

    // Next state: a differing tag completes the pair, expiry abandons the held beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = HOLD;
            HOLD: begin
                if (accept && (in_sel != hsel_q)) state_d = EMPTY;
                else if (expire)                  state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath: capture/replace the held beat, run the timeout, load or drain the output slot.
    always_comb begin
        hsel_d = hsel_q;
        hc_d   = hc_q;
        cnt_d  = cnt_q;
        drop_d = 1'b0;
        load   = 1'b0;
        ov_d   = ov_q;
        oa_d   = oa_q;
        ob_d   = ob_q;
        oe_d   = oe_q;
        if (ov_q && out_ready) ov_d = 1'b0;
        case (state_q)
            EMPTY: begin
                cnt_d = '0;
                if (accept) begin
                    hsel_d = in_sel;
                    hc_d   = in_c;
                end
            end
            HOLD: begin
                if (accept) begin
                    cnt_d = '0;
                    if (in_sel == hsel_q) begin
                        hc_d   = in_c;
                        drop_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end else if (expire) begin
                    cnt_d  = '0;
                    drop_d = 1'b1;
                end else if (TIMEOUT_CYC > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
        // Reload wins over the drain clear in the same cycle.
        if (load) begin
            ov_d = 1'b1;
            oa_d = sa;
            ob_d = sb;
            oe_d = se;
        end
    end

    assign out_valid  = ov_q;
    assign out_a      = oa_q;
    assign out_b      = ob_q;
    assign out_err    = oe_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_sum_diff_recover.sv
// Scoreboard bench for sum_diff_recover (TIMEOUT_CYC=4). Expected error bits follow SDR_CHECK_EN.
module tb_sum_diff_recover;

    localparam int DW = 8;
`ifdef SDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [1:0] S_A = 2'b00, S_B = 2'b01, S_SUM = 2'b10, S_DIFF = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_sel = '0;
    logic [DW:0]   in_c = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a, out_b;
    logic          out_err;
    logic          drop_pulse;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       err;
    } exp_t;

    exp_t expq[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   drop_cnt = 0;

    sum_diff_recover #(.DW(DW), .TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_c       (in_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_err    (out_err),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Monitor: counts drop pulses and pops the scoreboard on every output handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && drop_pulse) drop_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_pair: got a=%0h b=%0h, none required", out_a, out_b);
            end else begin
                e = expq.pop_front();
                check("out_a", 32'(out_a), 32'(e.a));
                check("out_b", 32'(out_b), 32'(e.b));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Present one beat from a negedge; returns at the negedge after it was accepted.
    task automatic send(input logic [1:0] s, input int c);
        int n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_c     = 9'(c);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pair(input logic [1:0] s0, input int c0, input logic [1:0] s1, input int c1,
                        input int ea, input int eb, input logic ee);
        exp_t e;
        e.a = 8'(ea);
        e.b = 8'(eb);
        e.err = ee;
        expq.push_back(e);
        send(s0, c0);
        send(s1, c1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed pairs, back to back, both beat orders
        pair(S_A, 5, S_B, -3, 5, -3, 1'b0);
        pair(S_B, -3, S_A, 5, 5, -3, 1'b0);
        pair(S_SUM, 100, S_DIFF, -20, 40, 60, 1'b0);
        pair(S_DIFF, -20, S_SUM, 100, 40, 60, 1'b0);
        pair(S_SUM, 255, S_DIFF, 1, 128, 127, CHK);
        pair(S_SUM, 7, S_DIFF, 2, 4, 2, CHK);
        pair(S_A, 10, S_SUM, -6, 10, -16, 1'b0);
        pair(S_A, 10, S_DIFF, 3, 10, 7, 1'b0);
        pair(S_B, 5, S_DIFF, -2, 3, 5, 1'b0);
        pair(S_A, 256, S_B, 1, 0, 1, CHK);
        pair(S_SUM, -7, S_DIFF, -3, -5, -2, 1'b0);
        pair(S_SUM, -3, S_DIFF, 0, -2, -2, CHK);
        wait_drain();
        check("no_spurious_drop", 32'(drop_cnt), 32'd0);

        // Same tag twice: second beat replaces the first
        expq.push_back(exp_t'{a: 8'd2, b: 8'd3, err: 1'b0});
        send(S_A, 1);
        send(S_A, 2);
        send(S_B, 3);
        wait_drain();
        check("dup_drop_count", 32'(drop_cnt), 32'd1);

        // Lone beat times out after 4 idle cycles
        send(S_A, 9);
        repeat (6) @(negedge clk);
        check("timeout_drop_count", 32'(drop_cnt), 32'd2);
        check("timeout_no_pair", 32'(out_valid), 32'd0);
        pair(S_B, -4, S_SUM, 6, 10, -4, 1'b0);
        wait_drain();

        // Backpressure: pair held, further beat blocked, data stable
        out_ready = 1'b0;
        expq.push_back(exp_t'{a: 8'd40, b: 8'd60, err: 1'b0});
        send(S_SUM, 100);
        send(S_DIFF, -20);
        in_valid = 1'b1;
        in_sel   = S_A;
        in_c     = 9'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_a", 32'(out_a), 32'd40);
            check("bp_out_b", 32'(out_b), 32'd60);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_queue", 32'(expq.size()), 32'd0);

        // Reset while holding a=7 clears everything
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_a", 32'(out_a), 32'd0);
        check("mid_rst_out_b", 32'(out_b), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pair(S_B, 3, S_DIFF, -2, 1, 3, 1'b0);
        wait_drain();

        check("final_drop_count", 32'(drop_cnt), 32'd2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
